// File: rtl/obstacle_scheduler_pkg.sv
// Shared types and constants for the obstacle spawner and the per-slot obstacle movers.
package obstacle_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRACE = 3'd1,
    WAIT  = 3'd2,
    PICK  = 3'd3,
    SPAWN = 3'd4
  } state_e;

  localparam logic CACTUS = 1'b0;
  localparam logic BIRD   = 1'b1;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int unsigned DEF_GAP_MIN    = 60;
  localparam int unsigned DEF_SPEED_INIT = 2;
  localparam int unsigned DEF_SPEED_MAX  = 6;

  localparam int unsigned TIMER_W  = 8;
  localparam int unsigned SPEED_W  = 4;
  localparam int unsigned HEIGHT_W = 4;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/obstacle_scheduler_lfsr16.sv
// 16-bit Galois LFSR, reloaded with the seed on reset and stepped when enabled.
module lfsr16
  import obstacle_scheduler_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic [15:0] i_seed,
  output logic [15:0] o_state
);

  logic [15:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (i_en) state_d = lfsr_next(state_q);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= i_seed;
    else       state_q <= state_d;
  end

  assign o_state = state_q;

endmodule

// File: rtl/obstacle_scheduler.sv
// Obstacle spawn sequencer: gap timer, free-slot picker and speed ramp.
// Define OBSTACLE_BIRD_EN to allow bird obstacles once the speed is high enough.
module obstacle_scheduler
  import obstacle_scheduler_pkg::*;
#(
  parameter int unsigned N_SLOTS        = 3,
  parameter int unsigned GAP_MIN        = DEF_GAP_MIN,
  parameter int unsigned GAP_RAND_BITS  = 6,
  parameter int unsigned RAMP_FRAMES    = 600,
  parameter int unsigned SPEED_INIT     = DEF_SPEED_INIT,
  parameter int unsigned SPEED_MAX      = DEF_SPEED_MAX,
  parameter int unsigned BIRD_MIN_SPEED = 4,
  parameter logic [15:0] SEED           = 16'hACE1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_ani_stb,
  input  logic                i_animate,
  input  logic                i_grace,
  input  logic [N_SLOTS-1:0]  i_slot_busy,
  output logic [N_SLOTS-1:0]  o_spawn,
  output logic                o_type,
  output logic [HEIGHT_W-1:0] o_height,
  output logic [SPEED_W-1:0]  o_speed,
  output logic                o_stall
);

  localparam int unsigned FRAME_W = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
  localparam logic [TIMER_W-1:0] GAP_MASK = TIMER_W'((32'd1 << GAP_RAND_BITS) - 32'd1);

  if (GAP_MIN + (2 ** GAP_RAND_BITS) - 1 > 255) begin : g_bad_gap
    $error("GAP_MIN plus random extension exceeds the 8-bit timer");
  end
  if (SEED == 16'h0000) begin : g_bad_seed
    $error("SEED must be non-zero");
  end
  if (BIRD_MIN_SPEED >= (2 ** SPEED_W)) begin : g_bad_bird
    $error("BIRD_MIN_SPEED does not fit in o_speed");
  end

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [SPEED_W-1:0]   speed_q, speed_d;
  logic [N_SLOTS-1:0]   spawn_q, spawn_d;
  logic                 type_q, type_d;
  logic [HEIGHT_W-1:0]  height_q, height_d;
  logic                 stall_q, stall_d;

  logic [15:0]          lfsr;
  logic                 lfsr_en_c;
  logic [N_SLOTS-1:0]   pick_c;
  logic                 found_c;
  logic                 type_c;
  logic                 unused_lfsr_c;

  assign lfsr_en_c     = i_ani_stb && (state_q != IDLE);
  assign unused_lfsr_c = ^lfsr[15:8];

  lfsr16 u_lfsr (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (lfsr_en_c),
    .i_seed  (SEED),
    .o_state (lfsr)
  );

  // Lowest-index free slot, re-evaluated every cycle.
  always_comb begin
    pick_c  = '0;
    found_c = 1'b0;
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      if (!i_slot_busy[i] && !found_c) begin
        pick_c[i] = 1'b1;
        found_c   = 1'b1;
      end
    end
  end

`ifdef OBSTACLE_BIRD_EN
  assign type_c = (speed_q >= SPEED_W'(BIRD_MIN_SPEED)) ? lfsr[8] : CACTUS;
`else
  assign type_c = CACTUS;
`endif

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    frame_d  = frame_q;
    speed_d  = speed_q;
    spawn_d  = '0;
    type_d   = type_q;
    height_d = height_q;
    stall_d  = 1'b0;
    if (!i_animate) begin
      state_d = IDLE;
    end else if (i_grace) begin
      state_d = GRACE;
      timer_d = TIMER_W'(GAP_MIN);
    end else begin
      // Speed ramp advances only while the game is actively scheduling.
      if (i_ani_stb && (state_q == WAIT || state_q == PICK || state_q == SPAWN)) begin
        if (frame_q == FRAME_W'(RAMP_FRAMES - 1)) begin
          frame_d = '0;
          if (speed_q < SPEED_W'(SPEED_MAX)) speed_d = speed_q + SPEED_W'(1);
        end else begin
          frame_d = frame_q + FRAME_W'(1);
        end
      end
      case (state_q)
        IDLE, GRACE: state_d = WAIT;
        WAIT: begin
          if (i_ani_stb) begin
            if (timer_q <= TIMER_W'(1)) state_d = PICK;
            else                        timer_d = timer_q - TIMER_W'(1);
          end
        end
        PICK: begin
          if (found_c) begin
            state_d  = SPAWN;
            spawn_d  = pick_c;
            type_d   = type_c;
            height_d = lfsr[7:4];
          end else begin
            stall_d = 1'b1;
          end
        end
        SPAWN: begin
          timer_d = TIMER_W'(GAP_MIN) + (lfsr[TIMER_W-1:0] & GAP_MASK);
          state_d = WAIT;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      timer_q  <= TIMER_W'(GAP_MIN);
      frame_q  <= '0;
      speed_q  <= SPEED_W'(SPEED_INIT);
      spawn_q  <= '0;
      type_q   <= CACTUS;
      height_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      frame_q  <= frame_d;
      speed_q  <= speed_d;
      spawn_q  <= spawn_d;
      type_q   <= type_d;
      height_q <= height_d;
      stall_q  <= stall_d;
    end
  end

  assign o_spawn  = spawn_q;
  assign o_type   = type_q;
  assign o_height = height_q;
  assign o_speed  = speed_q;
  assign o_stall  = stall_q;

endmodule
